dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache. It is the responder to the CPU's READ/WRITE/BUSYWAIT data-memory interface.
- Sits between the CPU datapath and the block-wide data memory. It stalls the CPU via BUSYWAIT on a miss.
- On a miss it writes back the dirty victim block, fetches the new block, then completes the access as a hit.

Parameters:
- INDEX_BITS, 3, log2 of number of cache lines (8 lines).
- OFFSET_BITS, 2, log2 of bytes per block (4-byte blocks).
- Derived, not overridable: TAG_BITS = 8-INDEX_BITS-OFFSET_BITS; BLOCK_W = 8<<OFFSET_BITS; MADDR_W = 8-OFFSET_BITS.

Ports:
- CLK  in  1  system clock, rising-edge.
- RESET  in  1  synchronous, active-high reset.
- READ  in  1  CPU load request (held until BUSYWAIT low).
- WRITE  in  1  CPU store request (held until BUSYWAIT low).
- ADDRESS  in  8  CPU byte address {tag,index,offset}.
- WRITEDATA  in  8  CPU store data.
- READDATA  out  8  load data.
- BUSYWAIT  out  1  stall to CPU.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block write-back request.
- MEM_ADDRESS  out  MADDR_W  block address {tag,index}.
- MEM_WRITEDATA  out  BLOCK_W  victim block.
- MEM_READDATA  in  BLOCK_W  fetched block; byte k = bits [8k+7:8k].
- MEM_BUSYWAIT  in  1  memory busy.

Behaviour:
- Reset:
  - Synchronous, active-high: on a CLK edge with RESET=1, all valid and dirty bits are cleared, state goes to IDLE, and the internal seen_busy flag is cleared.
  - Data and tag arrays are not cleared.
  - After reset: MEM_READ=MEM_WRITE=0, READDATA=0. BUSYWAIT=0 while no request is present.
  - Reset mid-miss abandons the memory transaction: MEM_* requests drop after the reset edge, and no array update occurs.
- State machine: IDLE, WRITEBACK, FETCH. State is registered; outputs are decoded from state plus inputs.
- hit = valid[idx] && tag[idx]==ADDRESS tag field.
- IDLE:
  - Outputs: MEM_READ=MEM_WRITE=0. BUSYWAIT=(READ|WRITE)&&!hit (combinational).
  - Read hit: READDATA = selected byte (combinational). Zero stall cycles.
  - Write hit: byte written and dirty[idx] set on the CLK edge; BUSYWAIT stays 0.
  - Miss: the request address is latched on the edge. Next state is WRITEBACK if valid&&dirty, else FETCH.
- WRITEBACK:
  - Outputs: MEM_WRITE=1, MEM_ADDRESS={victim tag, idx}, MEM_WRITEDATA=data[idx], BUSYWAIT=1.
  - Completes at the first edge sampling MEM_BUSYWAIT=0 after at least one edge sampled MEM_BUSYWAIT=1 (seen_busy handshake). Then next state is FETCH.
- FETCH:
  - Outputs: MEM_READ=1, MEM_ADDRESS=latched {tag,idx}, BUSYWAIT=1.
  - Completes with the same handshake. On the completion edge: data[idx]=MEM_READDATA, tag updated, valid=1, dirty=0; next state is IDLE.
- After a miss, the access resolves as a hit in IDLE on the following cycle.
- MEM_READ and MEM_WRITE are never both 1.
- seen_busy is cleared on every state change.
- READ and WRITE both 1: WRITE has priority.
- Neither request asserted: no array change, BUSYWAIT=0.
- The CPU holds ADDRESS/WRITEDATA stable while BUSYWAIT=1. The cache uses the latched address in WRITEBACK/FETCH regardless.
- READDATA holds its last value when READ=0.

Decomposition:
- Shared package dcache_pkg holds:
  - State enum {IDLE, WRITEBACK, FETCH}.
  - Derived width constants TAG_BITS, BLOCK_W, MADDR_W.
  - Tag/index/offset field-extract functions.
- One natural sub-module: dcache_byte_sel, a block-to-byte read mux plus a byte-lane write merge, used by both the hit path and the refill.
- FSM, arrays and handshake logic stay in dcache_controller.

Test Plan:
- Cold read miss: RESET, then READ ADDRESS=8'h14, memory returns block 32'hDDCCBBAA after 5 busy cycles -> MEM_READ=1 with MEM_ADDRESS=6'h05, no MEM_WRITE, BUSYWAIT=1 until refill, then READDATA=8'hAA and BUSYWAIT=0 one cycle later.
- Read hit after refill: READ 8'h17 -> BUSYWAIT never rises, READDATA=8'hDD in the same cycle.
- Write hit then dirty eviction: WRITE 8'h15 data 8'h5E (hit, 0 stalls); then READ 8'h34 (same idx 5, tag differs) -> MEM_WRITE=1, MEM_ADDRESS=6'h05, MEM_WRITEDATA=32'hDDCC5EAA, then MEM_READ with MEM_ADDRESS=6'h0D; strict sequence, never overlapping.
- Clean eviction: READ 8'h54 after a clean line at idx 5 -> FETCH only, no MEM_WRITE cycle.
- Reset mid-FETCH: assert RESET while MEM_READ=1 -> MEM_READ=0 after the reset edge, state IDLE, a subsequent READ 8'h14 misses again.
- READ and WRITE both 1 at 8'h00 on a hit -> treated as a store: byte updated, dirty set, no stall.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types, derived widths and address-field helpers for the data cache.
package dcache_pkg;

    localparam int unsigned ADDR_W          = 8;
    localparam int unsigned INDEX_BITS      = 3;
    localparam int unsigned OFFSET_BITS     = 2;
    localparam int unsigned TAG_BITS        = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned BLOCK_W         = 8 << OFFSET_BITS;
    localparam int unsigned MADDR_W         = ADDR_W - OFFSET_BITS;
    localparam int unsigned NUM_LINES       = 1 << INDEX_BITS;
    localparam int unsigned BYTES_PER_BLOCK = 1 << OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_e;

    // CPU byte address split into its cache fields, MSB first.
    typedef struct packed {
        logic [TAG_BITS-1:0]    tag;
        logic [INDEX_BITS-1:0]  index;
        logic [OFFSET_BITS-1:0] offset;
    } addr_fields_t;

    function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] addr);
        return addr_fields_t'(addr);
    endfunction

    function automatic logic [MADDR_W-1:0] block_addr(input logic [TAG_BITS-1:0]   tag,
                                                      input logic [INDEX_BITS-1:0] index);
        return {tag, index};
    endfunction

endpackage

// File: rtl/dcache_byte_sel.sv
// Byte-lane read mux and byte-lane write merge over one cache block.
module dcache_byte_sel
    import dcache_pkg::*;
(
    input  logic [BLOCK_W-1:0]     block_i,
    input  logic [OFFSET_BITS-1:0] offset_i,
    input  logic [7:0]             wdata_i,
    output logic [7:0]             rbyte_o,
    output logic [BLOCK_W-1:0]     merged_o
);

    // Select the addressed byte and build the block with that byte replaced.
    always_comb begin
        rbyte_o  = 8'h00;
        merged_o = block_i;
        for (int unsigned k = 0; k < BYTES_PER_BLOCK; k++) begin
            if (offset_i == OFFSET_BITS'(k)) begin
                rbyte_o           = block_i[8*k +: 8];
                merged_o[8*k +: 8] = wdata_i;
            end
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back / write-allocate data cache between CPU and block memory.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 READ,
    input  logic                 WRITE,
    input  logic [ADDR_W-1:0]    ADDRESS,
    input  logic [7:0]           WRITEDATA,
    output logic [7:0]           READDATA,
    output logic                 BUSYWAIT,
    output logic                 MEM_READ,
    output logic                 MEM_WRITE,
    output logic [MADDR_W-1:0]   MEM_ADDRESS,
    output logic [BLOCK_W-1:0]   MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]   MEM_READDATA,
    input  logic                 MEM_BUSYWAIT
);

    logic [BLOCK_W-1:0]    data_q  [NUM_LINES];
    logic [TAG_BITS-1:0]   tag_q   [NUM_LINES];
    logic [NUM_LINES-1:0]  valid_q;
    logic [NUM_LINES-1:0]  dirty_q;
    state_e                state_q;
    logic                  seen_busy_q;
    logic [MADDR_W-1:0]    miss_addr_q;
    logic [7:0]            readdata_q;

    addr_fields_t          req;
    logic                  hit;
    logic                  mem_done;
    logic [INDEX_BITS-1:0] miss_idx;
    logic [TAG_BITS-1:0]   miss_tag;
    logic [7:0]            hit_byte;
    logic [BLOCK_W-1:0]    merged_block;

    assign req      = split_addr(ADDRESS);
    assign hit      = valid_q[req.index] && (tag_q[req.index] == req.tag);
    assign mem_done = seen_busy_q && !MEM_BUSYWAIT;
    assign miss_idx = miss_addr_q[INDEX_BITS-1:0];
    assign miss_tag = miss_addr_q[MADDR_W-1 -: TAG_BITS];

    dcache_byte_sel u_byte_sel (
        .block_i  (data_q[req.index]),
        .offset_i (req.offset),
        .wdata_i  (WRITEDATA),
        .rbyte_o  (hit_byte),
        .merged_o (merged_block)
    );

    // State, line arrays and memory handshake; a memory transfer completes on the
    // first idle-memory edge after memory has been seen busy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            seen_busy_q <= 1'b0;
            miss_addr_q <= '0;
            readdata_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((READ || WRITE) && !hit) begin
                        miss_addr_q <= block_addr(req.tag, req.index);
                        seen_busy_q <= 1'b0;
                        state_q     <= (valid_q[req.index] && dirty_q[req.index]) ? WRITEBACK : FETCH;
                    end else if (WRITE) begin
                        data_q[req.index]  <= merged_block;
                        dirty_q[req.index] <= 1'b1;
                    end else if (READ) begin
                        readdata_q <= hit_byte;
                    end
                end
                WRITEBACK: begin
                    if (mem_done) begin
                        seen_busy_q <= 1'b0;
                        state_q     <= FETCH;
                    end else if (MEM_BUSYWAIT) begin
                        seen_busy_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_done) begin
                        data_q[miss_idx]  <= MEM_READDATA;
                        tag_q[miss_idx]   <= miss_tag;
                        valid_q[miss_idx] <= 1'b1;
                        dirty_q[miss_idx] <= 1'b0;
                        seen_busy_q       <= 1'b0;
                        state_q           <= IDLE;
                    end else if (MEM_BUSYWAIT) begin
                        seen_busy_q <= 1'b1;
                    end
                end
                default: begin
                    seen_busy_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // CPU stall, load data and memory request decode from state and request.
    always_comb begin
        READDATA      = readdata_q;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        case (state_q)
            IDLE: begin
                BUSYWAIT = (READ || WRITE) && !hit;
                if (READ && hit) begin
                    READDATA = hit_byte;
                end
            end
            WRITEBACK: begin
                BUSYWAIT      = 1'b1;
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = block_addr(tag_q[miss_idx], miss_idx);
                MEM_WRITEDATA = data_q[miss_idx];
            end
            FETCH: begin
                BUSYWAIT    = 1'b1;
                MEM_READ    = 1'b1;
                MEM_ADDRESS = miss_addr_q;
            end
            default: begin
                BUSYWAIT = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a latency-modelled block memory.
module tb_dcache_controller;

    logic        CLK;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    dcache_controller dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam int MEM_LAT = 5;

    typedef struct {
        logic        is_write;
        logic [5:0]  addr;
        logic [31:0] data;
    } op_t;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wd;
        logic       exp_busy;
        logic       chk_rd;
        logic [7:0] exp_rd;
    } vec_t;

    logic [31:0] mem [64];
    op_t         ops [$];
    logic        busy_active;
    int          lat_cnt;
    int          overlap_cnt;
    int          nostall_cnt;
    int          tests;
    int          fails;

    // Block memory: each new request is busy for MEM_LAT cycles, then completes.
    always @(negedge CLK) begin
        if (MEM_READ && MEM_WRITE) overlap_cnt++;
        if ((MEM_READ || MEM_WRITE) && !BUSYWAIT) nostall_cnt++;
        if (MEM_READ || MEM_WRITE) begin
            if (!busy_active) begin
                busy_active  = 1'b1;
                lat_cnt      = MEM_LAT;
                MEM_BUSYWAIT = 1'b1;
                ops.push_back('{MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA});
            end else if (lat_cnt > 1) begin
                lat_cnt--;
            end else begin
                if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
                else           MEM_READDATA     = mem[MEM_ADDRESS];
                MEM_BUSYWAIT = 1'b0;
                busy_active  = 1'b0;
            end
        end else begin
            busy_active  = 1'b0;
            MEM_BUSYWAIT = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One CPU access held until BUSYWAIT drops; returns the load byte seen then.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, output logic [7:0] rdata,
                          output int stalls, output logic ok);
        @(negedge CLK);
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
        #1;
        stalls = 0;
        while (BUSYWAIT && stalls < 200) begin
            @(negedge CLK);
            #1;
            stalls++;
        end
        ok    = !BUSYWAIT;
        rdata = READDATA;
        @(posedge CLK);
        #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    vec_t       vecs [10];
    logic [7:0] rdata;
    int         stalls;
    logic       ok;
    int         wait_cnt;

    initial begin
        tests = 0; fails = 0; overlap_cnt = 0; nostall_cnt = 0;
        busy_active = 1'b0; lat_cnt = 0;
        MEM_BUSYWAIT = 1'b0; MEM_READDATA = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[6'h05] = 32'hDDCCBBAA;
        mem[6'h0D] = 32'h44332211;
        mem[6'h15] = 32'h88776655;
        mem[6'h00] = 32'h03020100;

        vecs[0] = '{1'b1, 1'b0, 8'h17, 8'h00, 1'b0, 1'b1, 8'hDD};
        vecs[1] = '{1'b1, 1'b0, 8'h16, 8'h00, 1'b0, 1'b1, 8'hCC};
        vecs[2] = '{1'b1, 1'b0, 8'h15, 8'h00, 1'b0, 1'b1, 8'hBB};
        vecs[3] = '{1'b0, 1'b1, 8'h15, 8'h5E, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 8'h15, 8'h00, 1'b0, 1'b1, 8'h5E};
        vecs[5] = '{1'b1, 1'b0, 8'h14, 8'h00, 1'b0, 1'b1, 8'hAA};
        vecs[6] = '{1'b1, 1'b1, 8'h00, 8'h7F, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h7F};
        vecs[8] = '{1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 8'h01};
        vecs[9] = '{1'b0, 1'b0, 8'h17, 8'h00, 1'b0, 1'b1, 8'h01};

        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("reset_busywait", 32'(BUSYWAIT), 32'd0);
        check("reset_mem_read", 32'(MEM_READ), 32'd0);
        check("reset_mem_write", 32'(MEM_WRITE), 32'd0);
        check("reset_readdata", 32'(READDATA), 32'h00);

        // Cold read miss on line 5.
        ops.delete();
        access(1'b1, 1'b0, 8'h14, 8'h00, rdata, stalls, ok);
        check("cold_done", 32'(ok), 32'd1);
        check("cold_stalled", 32'(stalls > 0), 32'd1);
        check("cold_readdata", 32'(rdata), 32'hAA);
        check("cold_op_count", 32'(ops.size()), 32'd1);
        if (ops.size() > 0) begin
            check("cold_op_is_read", 32'(ops[0].is_write), 32'd0);
            check("cold_op_addr", 32'(ops[0].addr), 32'h05);
        end

        // Fill line 0 for the read+write case.
        ops.delete();
        access(1'b1, 1'b0, 8'h00, 8'h00, rdata, stalls, ok);
        check("line0_readdata", 32'(rdata), 32'h00);
        check("line0_op_count", 32'(ops.size()), 32'd1);

        // Single-cycle hit behaviour.
        foreach (vecs[i]) begin
            @(negedge CLK);
            READ = vecs[i].rd; WRITE = vecs[i].wr;
            ADDRESS = vecs[i].addr; WRITEDATA = vecs[i].wd;
            #1;
            check($sformatf("vec%0d_busywait", i), 32'(BUSYWAIT), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_memreq", i), 32'({MEM_READ, MEM_WRITE}), 32'd0);
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d_readdata", i), 32'(READDATA), 32'(vecs[i].exp_rd));
            @(posedge CLK);
        end
        #1;
        READ = 1'b0; WRITE = 1'b0;

        // Dirty eviction: write-back of the merged block, then fetch.
        ops.delete();
        access(1'b1, 1'b0, 8'h34, 8'h00, rdata, stalls, ok);
        check("evict_done", 32'(ok), 32'd1);
        check("evict_readdata", 32'(rdata), 32'h11);
        check("evict_op_count", 32'(ops.size()), 32'd2);
        if (ops.size() == 2) begin
            check("evict_op0_write", 32'(ops[0].is_write), 32'd1);
            check("evict_op0_addr", 32'(ops[0].addr), 32'h05);
            check("evict_op0_data", ops[0].data, 32'hDDCC5EAA);
            check("evict_op1_read", 32'(ops[1].is_write), 32'd0);
            check("evict_op1_addr", 32'(ops[1].addr), 32'h0D);
        end
        check("evict_mem_updated", mem[6'h05], 32'hDDCC5EAA);

        // Clean eviction: fetch only.
        ops.delete();
        access(1'b1, 1'b0, 8'h54, 8'h00, rdata, stalls, ok);
        check("clean_readdata", 32'(rdata), 32'h55);
        check("clean_op_count", 32'(ops.size()), 32'd1);
        if (ops.size() > 0) begin
            check("clean_op_is_read", 32'(ops[0].is_write), 32'd0);
            check("clean_op_addr", 32'(ops[0].addr), 32'h15);
        end

        // Reset in the middle of a fetch.
        @(negedge CLK);
        READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h14;
        wait_cnt = 0;
        #1;
        while (!MEM_READ && wait_cnt < 20) begin
            @(negedge CLK);
            #1;
            wait_cnt++;
        end
        check("midfetch_mem_read_seen", 32'(MEM_READ), 32'd1);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("midfetch_mem_read_drop", 32'(MEM_READ), 32'd0);
        check("midfetch_mem_write_drop", 32'(MEM_WRITE), 32'd0);
        READ = 1'b0; RESET = 1'b0;
        @(negedge CLK);
        #1;
        check("midfetch_idle_busywait", 32'(BUSYWAIT), 32'd0);

        ops.delete();
        access(1'b1, 1'b0, 8'h14, 8'h00, rdata, stalls, ok);
        check("post_reset_miss_stalled", 32'(stalls > 0), 32'd1);
        check("post_reset_readdata", 32'(rdata), 32'hAA);
        check("post_reset_op_count", 32'(ops.size()), 32'd1);

        // Dirty line 0 was invalidated by reset: plain fetch, no write-back.
        ops.delete();
        access(1'b1, 1'b0, 8'h00, 8'h00, rdata, stalls, ok);
        check("line0_after_reset_ops", 32'(ops.size()), 32'd1);
        if (ops.size() > 0) check("line0_after_reset_is_read", 32'(ops[0].is_write), 32'd0);
        check("line0_after_reset_readdata", 32'(rdata), 32'h00);

        check("mem_read_write_overlap", 32'(overlap_cnt), 32'd0);
        check("mem_req_without_stall", 32'(nostall_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
